sib_key_driver: RTL and testbench

SIB_KEY_DRIVER -- requirements
Module: sib_key_driver

---
 rtl/sib_key_pkg.sv | 33 +++
 rtl/key_piso.sv | 36 +++
 rtl/sib_key_driver.sv | 161 ++++++++++++++++
 tb/tb_sib_key_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sib_key_pkg.sv
// Shared definitions for the SIB key driver: FSM encoding and scan-control decode.
// SIB_EXTRA_BITS is the number of SIB cells that follow the key register in the chain.
package sib_key_pkg;

  localparam int SIB_EXTRA_BITS = 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPTURE  = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_UPDATE   = 3'd3;
  localparam logic [2:0] S_VCAPTURE = 3'd4;
  localparam logic [2:0] S_VSHIFT   = 3'd5;
  localparam logic [2:0] S_VUPDATE  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  typedef struct packed {
    logic select;
    logic capture;
    logic shift;
    logic update;
  } scan_ctl_t;

  function automatic scan_ctl_t ctl_of(input logic [2:0] s);
    scan_ctl_t c;
    c = '0;
    c.capture = (s == S_CAPTURE) || (s == S_VCAPTURE);
    c.shift   = (s == S_SHIFT)   || (s == S_VSHIFT);
    c.update  = (s == S_UPDATE)  || (s == S_VUPDATE);
    c.select  = c.capture | c.shift | c.update;
    return c;
  endfunction

endpackage

// File: rtl/key_piso.sv
// Parallel-load serial-out register, MSB first; restart replays the last
// loaded word so a second pass emits the identical bit stream.
module key_piso
  import sib_key_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         restart,
  input  logic         shift,
  input  logic [W-1:0] data,
  output logic         sout
);

  logic [W-1:0] hold;
  logic [W-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      sreg <= '0;
    end else if (load) begin
      hold <= data;
      sreg <= data;
    end else if (restart) begin
      sreg <= hold;
    end else if (shift) begin
      sreg <= {sreg[W-2:0], 1'b0};
    end
  end

  assign sout = sreg[W-1];

endmodule

// File: rtl/sib_key_driver.sv
// Programs a key register + SIB scan chain, optionally re-scanning to verify.
// Build option: SIB_KEY_DRIVER_VERIFY_EN enables the verify pass.
module sib_key_driver
  import sib_key_pkg::*;
#(
  parameter int Length = 128
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [Length-1:0] Key,
  input  logic              OpenReq,
  input  logic              SO,
  output logic              SI,
  output logic              ShiftEN,
  output logic              CaptureEN,
  output logic              UpdateEn,
  output logic              Select,
  output logic              Busy,
  output logic              Done,
  output logic              Opened,
  output logic              Error
);

  localparam int N  = Length + SIB_EXTRA_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt;
  logic          open_q;
  logic          accept;
  logic          in_shift;
  logic          sout;
  scan_ctl_t     ctl;

  assign accept   = (state == S_IDLE) && Start;
  assign in_shift = (state == S_SHIFT) || (state == S_VSHIFT);
  assign ctl      = ctl_of(state);

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:     if (Start) state_nx = S_CAPTURE;
      S_CAPTURE:  state_nx = S_SHIFT;
      S_SHIFT:    if (cnt == LAST) state_nx = S_UPDATE;
`ifdef SIB_KEY_DRIVER_VERIFY_EN
      S_UPDATE:   state_nx = S_VCAPTURE;
`else
      S_UPDATE:   state_nx = S_DONE;
`endif
      S_VCAPTURE: state_nx = S_VSHIFT;
      S_VSHIFT:   if (cnt == LAST) state_nx = S_VUPDATE;
      S_VUPDATE:  state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Counter restarts on every state change, so each shift pass begins at 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (in_shift) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      open_q <= 1'b0;
    end else if (accept) begin
      open_q <= OpenReq;
    end
  end

  key_piso #(
    .W (N)
  ) u_piso (
    .clk     (Clock),
    .rst     (Reset),
    .load    (accept),
    .restart (state == S_VCAPTURE),
    .shift   (in_shift),
    .data    ({OpenReq, Key}),
    .sout    (sout)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      SI        <= 1'b0;
      ShiftEN   <= 1'b0;
      CaptureEN <= 1'b0;
      UpdateEn  <= 1'b0;
      Select    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      SI        <= in_shift & sout;
      ShiftEN   <= ctl.shift;
      CaptureEN <= ctl.capture;
      UpdateEn  <= ctl.update;
      Select    <= ctl.select;
      Busy      <= (state != S_IDLE);
      Done      <= (state == S_DONE);
    end
  end

`ifdef SIB_KEY_DRIVER_VERIFY_EN
  // High while the chain presents the captured SIB bit on SO.
  logic v_first;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      v_first <= 1'b0;
    end else begin
      v_first <= (state == S_VSHIFT) && (cnt == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Opened <= 1'b0;
      Error  <= 1'b0;
    end else if (accept) begin
      Opened <= 1'b0;
      Error  <= 1'b0;
    end else if (v_first) begin
      Opened <= SO;
      Error  <= open_q & ~SO;
    end
  end
`else
  logic unused_so;
  assign unused_so = SO;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Opened <= 1'b0;
      Error  <= 1'b0;
    end else if (accept) begin
      Opened <= 1'b0;
      Error  <= 1'b0;
    end else if (state == S_UPDATE) begin
      Opened <= open_q;
      Error  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sib_key_driver.sv
// Randomised scoreboard bench for sib_key_driver with an 8-bit key and
// a behavioural key-register + SIB chain model on SI/SO.
module tb_sib_key_driver;

  localparam int L = 8;
  localparam int N = L + 1;
`ifdef SIB_KEY_DRIVER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int LAT    = VER ? 2 * N + 5 : N + 3;
  localparam int PASSES = VER ? 2 : 1;
  localparam int REP2   = VER ? 15 : 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [L-1:0] key = '0;
  logic         open_req = 1'b0;
  logic         so;
  logic         si, shift_en, capture_en, update_en, sel;
  logic         busy, done, opened, error;

  sib_key_driver #(
    .Length (L)
  ) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Start     (start),
    .Key       (key),
    .OpenReq   (open_req),
    .SO        (so),
    .SI        (si),
    .ShiftEN   (shift_en),
    .CaptureEN (capture_en),
    .UpdateEn  (update_en),
    .Select    (sel),
    .Busy      (busy),
    .Done      (done),
    .Opened    (opened),
    .Error     (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Chain: SI -> 8-bit key cells -> SIB cell -> SO; SIB opens only on key A5.
  logic [N-1:0] chain = '0;
  logic [L-1:0] key_upd = '0;
  logic         sib_upd = 1'b0;
  assign so = chain[N-1];

  always @(posedge clk) begin
    if (rst) begin
      chain   <= '0;
      key_upd <= '0;
      sib_upd <= 1'b0;
    end else begin
      if (capture_en) chain <= {sib_upd, key_upd};
      else if (shift_en) chain <= {chain[N-2:0], si};
      if (update_en) begin
        key_upd <= chain[L-1:0];
        sib_upd <= chain[N-1] && (chain[L-1:0] == 8'hA5);
      end
    end
  end

  typedef struct {
    int t0;
    bit opened;
    bit error;
  } exp_t;

  exp_t exp_q[$];
  bit   si_q[$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   upd_seen = 0;
  int   cap_seen = 0;
  bit   last_open;
  bit   last_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (update_en) upd_seen++;
      if (capture_en) cap_seen++;
      if (shift_en) begin
        if (si_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL si_extra: shift with no expected bit at cycle %0d",
                   cyc);
        end else begin
          chk("si", 32'(si), 32'(si_q.pop_front()));
        end
      end else if (busy) begin
        chk("si_idle", 32'(si), 0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_unexpected: Done=1 with nothing pending at cycle %0d",
                   cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("latency", 32'(cyc - e.t0), 32'(LAT));
          chk("opened", 32'(opened), 32'(e.opened));
          chk("error", 32'(error), 32'(e.error));
          chk("update_pulses", 32'(upd_seen), 32'(PASSES));
          chk("capture_pulses", 32'(cap_seen), 32'(PASSES));
          chk("busy_at_done", 32'(busy), 1);
        end
        done_cnt++;
      end
    end
  end

  function automatic logic [8:0] outs();
    return {si, shift_en, capture_en, update_en, sel, busy, done, opened,
            error};
  endfunction

  // Issues one request from a posedge+#1 point; optionally re-pulses Start
  // with a zero key while the sequence runs.
  task automatic run_txn(input logic [L-1:0] k, input bit o, input bit rep);
    int t0;
    int d0;
    exp_t e;
    bit got;
    key = k;
    open_req = o;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    key = L'($urandom);
    open_req = 1'($urandom);
    upd_seen = 0;
    cap_seen = 0;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < N; i++)
        si_q.push_back(i == 0 ? o : k[L-i]);
    e.t0 = t0;
    e.opened = VER ? (o && k == 8'hA5) : o;
    e.error = o && !e.opened;
    exp_q.push_back(e);
    last_open = e.opened;
    last_err = e.error;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      if (done_cnt != d0) begin
        got = 1'b1;
        break;
      end
      if (rep && ((cyc - t0) == 2 || (cyc - t0) == REP2 - 1)) begin
        start = 1'b1;
        key = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no Done within %0d cycles", LAT + 20);
      exp_q.delete();
      si_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    chk("opened_hold", 32'(opened), 32'(last_open));
    chk("error_hold", 32'(error), 32'(last_err));
    chk("idle_busy", 32'(busy), 0);
    chk("sib_state", 32'(sib_upd), 32'(o && k == 8'hA5));
  endtask

  task automatic mid_reset();
    int t0;
    key = 8'hA5;
    open_req = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
    for (int p = 0; p < PASSES; p++)
      for (int i = 0; i < N; i++)
        si_q.push_back(i == 0 ? 1'b1 : key[L-i]);
    while (cyc - t0 < 4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    si_q.delete();
    upd_seen = 0;
    chk("reset_mid_outs", 32'(outs()), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("reset_no_update", 32'(upd_seen), 0);
    chk("reset_idle", 32'(outs()), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_outs", 32'(outs()), 0);

    run_txn(8'hA5, 1'b1, 1'b0);
    run_txn(8'h5A, 1'b1, 1'b0);
    run_txn(8'hA5, 1'b0, 1'b0);
    run_txn(8'hA5, 1'b1, 1'b1);
    mid_reset();
    run_txn(8'hA5, 1'b1, 1'b0);

    for (int n = 0; n < 12; n++) begin
      logic [L-1:0] k;
      k = ($urandom_range(0, 1) == 1) ? 8'hA5 : L'($urandom);
      run_txn(k, 1'($urandom), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    chk("pending_results", 32'(exp_q.size()), 0);
    chk("pending_si", 32'(si_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
